// File: rtl/mat_dec_sender_if.sv
// Handshake and memory-read bundle between mat_dec_sender and its
// environment (byte memory plus the uart transmit side).
interface mat_dec_sender_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;

    modport master (
        input  start, rd_data, is_transmitting,
        output busy, done, rd_addr, transmit, tx_byte
    );

    modport slave (
        output start, rd_data, is_transmitting,
        input  busy, done, rd_addr, transmit, tx_byte
    );
endinterface

// File: rtl/mat_dec_sender.sv
// Streams COUNT byte values from a byte memory as three-digit decimal ASCII
// over the uart transmit handshake. Values are separated by SEP, and every
// LINE_LEN-th value (and the last one) is terminated by CR LF.
module mat_dec_sender #(
    parameter int unsigned COUNT    = 36,
    parameter int unsigned LINE_LEN = 4,
    parameter logic [7:0]  SEP      = 8'h20
) (
    input logic              clk,
    input logic              reset,
    mat_dec_sender_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CONV,
        S_LOAD,
        S_WAIT,
        S_SEND,
        S_NEXT
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);
    localparam logic [7:0] LAST_COL = 8'(LINE_LEN - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  value;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [2:0]  bit_cnt;
    logic [7:0]  rd_addr_q;
    logic [7:0]  line_cnt;
    logic        eol;
    logic [2:0]  char_idx;
    logic [7:0]  tx_byte_q;
    logic [7:0]  char_next;
    logic        busy_q;
    logic        done_q;
    logic        accept;
    logic        last_val;
    logic        more_chars;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // A start arriving together with the done pulse is dropped: the block
    // only counts as idle once done has cleared.
    assign accept     = (state == S_IDLE) && bus.start && !done_q;
    assign last_val   = (rd_addr_q == LAST_IDX);
    assign more_chars = char_idx < (eol ? 3'd5 : 3'd4);

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.tx_byte  = tx_byte_q;
    assign bus.transmit = (state == S_WAIT);

    // Add-3 correction of every BCD digit ahead of the next shift.
    always_comb begin
        bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    end

    // Character for position char_idx; position 0 is issued directly in LOAD.
    always_comb begin
        char_next = SEP;
        case (char_idx)
            3'd1:    char_next = 8'h30 + {4'h0, bcd[7:4]};
            3'd2:    char_next = 8'h30 + {4'h0, bcd[3:0]};
            3'd3:    char_next = eol ? 8'h0D : SEP;
            3'd4:    char_next = 8'h0A;
            default: char_next = SEP;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_CONV;
            S_CONV:  if (bit_cnt == 3'd7) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_WAIT;
            S_WAIT:  if (bus.is_transmitting) state_nxt = S_SEND;
            S_SEND:  if (!bus.is_transmitting) state_nxt = S_NEXT;
            S_NEXT: begin
                if (more_chars) begin
                    state_nxt = S_WAIT;
                end else if (!last_val) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: fetch, double-dabble conversion, character sequencing, status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value     <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            rd_addr_q <= '0;
            line_cnt  <= '0;
            eol       <= 1'b0;
            char_idx  <= '0;
            tx_byte_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (done_q) begin
                        busy_q <= 1'b0;
                    end else if (accept) begin
                        busy_q    <= 1'b1;
                        rd_addr_q <= '0;
                        line_cnt  <= '0;
                    end
                end
                S_FETCH: begin
                    value   <= bus.rd_data;
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                S_CONV: begin
                    bcd     <= {bcd_adj[10:0], value[7]};
                    value   <= {value[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                S_LOAD: begin
                    tx_byte_q <= 8'h30 + {4'h0, bcd[11:8]};
                    char_idx  <= 3'd1;
                    eol       <= last_val || (line_cnt == LAST_COL);
                end
                S_NEXT: begin
                    if (more_chars) begin
                        tx_byte_q <= char_next;
                        char_idx  <= char_idx + 3'd1;
                    end else if (!last_val) begin
                        rd_addr_q <= rd_addr_q + 8'd1;
                        line_cnt  <= eol ? 8'd0 : line_cnt + 8'd1;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
